// File: rtl/pc_ctx_bank.sv
// Banked program counter with NUM_CTX contexts, a one-cycle handshaked context
// switch, and a preemption quantum timer that interrupts the OS context.
module pc_ctx_bank #(
    parameter int                ADDR_W       = 10,
    parameter int                NUM_CTX      = 4,
    parameter int                CTX_W        = 2,
    parameter int                QUANTUM_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hlt,
    input  logic [ADDR_W-1:0]    address,
    input  logic                 bios_reset,
    input  logic                 ctx_clear,
    input  logic                 sw_req,
    input  logic [CTX_W-1:0]     sw_ctx,
    output logic                 sw_ack,
    output logic                 sw_err,
    input  logic [QUANTUM_W-1:0] quantum,
    input  logic                 irq_ack,
    output logic                 timer_irq,
    output logic [CTX_W-1:0]     active_ctx,
    output logic [ADDR_W-1:0]    outPC,
    input  logic [CTX_W-1:0]     probe_ctx,
    output logic [ADDR_W-1:0]    probe_pc
);

    typedef enum logic {RUN, SWITCH} state_t;

    state_t                         state;
    logic   [CTX_W-1:0]             target;
    logic   [QUANTUM_W-1:0]         qcnt;
    logic   [NUM_CTX-1:0][ADDR_W-1:0] pc;

    logic                 run;
    logic                 count_en;
    logic                 expire;
    logic [QUANTUM_W:0]   qnext;

    assign run      = (state == RUN);
    assign count_en = run && (active_ctx != '0) && !hlt && !timer_irq && (quantum != '0);
    assign qnext    = {1'b0, qcnt} + (QUANTUM_W+1)'(1);
    // >= rather than == so a quantum lowered below the running count still fires
    assign expire   = count_en && (qnext >= {1'b0, quantum});

    // Only the active context's register ever loads; SWITCH suppresses updates
    for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
        logic [ADDR_W-1:0] q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                q <= RESET_VECTOR;
            else if (bios_reset)
                q <= RESET_VECTOR;
            else if (run && active_ctx == CTX_W'(i)) begin
                if (ctx_clear)
                    q <= RESET_VECTOR;
                else if (!hlt)
                    q <= address;
            end
        end
        assign pc[i] = q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            active_ctx <= '0;
            target     <= '0;
            qcnt       <= '0;
            timer_irq  <= 1'b0;
            sw_ack     <= 1'b0;
            sw_err     <= 1'b0;
        end else begin
            sw_ack <= 1'b0;
            sw_err <= 1'b0;
            if (bios_reset) begin
                state      <= RUN;
                active_ctx <= '0;
                qcnt       <= '0;
                timer_irq  <= 1'b0;
            end else begin
                if (expire)
                    timer_irq <= 1'b1;
                else if (irq_ack)
                    timer_irq <= 1'b0;

                if (quantum == '0 || expire)
                    qcnt <= '0;
                else if (count_en)
                    qcnt <= qnext[QUANTUM_W-1:0];

                // Later assignments below override the counter update above
                case (state)
                    RUN: begin
                        if (sw_req) begin
                            if (int'(sw_ctx) >= NUM_CTX)
                                sw_err <= 1'b1;
                            else if (sw_ctx == active_ctx) begin
                                sw_ack <= 1'b1;
                                qcnt   <= '0;
                            end else begin
                                target <= sw_ctx;
                                state  <= SWITCH;
                            end
                        end
                    end
                    SWITCH: begin
                        active_ctx <= target;
                        qcnt       <= '0;
                        sw_ack     <= 1'b1;
                        state      <= RUN;
                    end
                endcase
            end
        end
    end

    always_comb begin
        outPC    = '0;
        probe_pc = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (active_ctx == CTX_W'(i)) outPC = pc[i];
            if (probe_ctx == CTX_W'(i))  probe_pc = pc[i];
        end
    end

endmodule

// File: tb/tb_pc_ctx_bank.sv
// Randomized + directed bench for pc_ctx_bank against a cycle-level reference model.
module tb_pc_ctx_bank;
    localparam int ADDR_W = 10, NUM_CTX = 4, CTX_W = 3, QUANTUM_W = 16;
    localparam logic [ADDR_W-1:0] RV = '0;

    logic clk = 0, reset = 0, hlt = 0, bios_reset = 0, ctx_clear = 0, sw_req = 0, irq_ack = 0;
    logic [ADDR_W-1:0]    address = '0;
    logic [CTX_W-1:0]     sw_ctx = '0, probe_ctx = '0;
    logic [QUANTUM_W-1:0] quantum = '0;
    logic                 sw_ack, sw_err, timer_irq;
    logic [CTX_W-1:0]     active_ctx;
    logic [ADDR_W-1:0]    outPC, probe_pc;

    always #5 clk = ~clk;

    pc_ctx_bank #(.ADDR_W(ADDR_W), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W),
                  .QUANTUM_W(QUANTUM_W), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .hlt(hlt), .address(address), .bios_reset(bios_reset),
        .ctx_clear(ctx_clear), .sw_req(sw_req), .sw_ctx(sw_ctx), .sw_ack(sw_ack), .sw_err(sw_err),
        .quantum(quantum), .irq_ack(irq_ack), .timer_irq(timer_irq), .active_ctx(active_ctx),
        .outPC(outPC), .probe_ctx(probe_ctx), .probe_pc(probe_pc));

    int n_chk = 0, n_err = 0;

    // Reference model: what each context holds and what the handshake has promised
    int m_pc[NUM_CTX];
    int m_act, m_tgt, m_cnt;
    bit m_sw, m_irq, m_ack, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h @%0t", tag, got, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pc[i]) m_pc[i] = int'(RV);
        m_act = 0; m_tgt = 0; m_cnt = 0;
        m_sw = 0; m_irq = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit fire = 0;
        m_ack = 0; m_err = 0;
        if (bios_reset) begin
            foreach (m_pc[i]) m_pc[i] = int'(RV);
            m_act = 0; m_sw = 0; m_cnt = 0; m_irq = 0;
            return;
        end
        if (m_sw) begin
            m_act = m_tgt; m_sw = 0; m_cnt = 0; m_ack = 1;
        end else begin
            if (ctx_clear) m_pc[m_act] = int'(RV);
            else if (!hlt) m_pc[m_act] = int'(address);
            if (quantum == 0) m_cnt = 0;
            else if (m_act != 0 && !hlt && !m_irq) begin
                if (m_cnt + 1 >= int'(quantum)) begin fire = 1; m_cnt = 0; end
                else m_cnt++;
            end
            if (sw_req) begin
                if (int'(sw_ctx) >= NUM_CTX) m_err = 1;
                else if (int'(sw_ctx) == m_act) begin m_ack = 1; m_cnt = 0; end
                else begin m_sw = 1; m_tgt = int'(sw_ctx); end
            end
        end
        if (fire) m_irq = 1;
        else if (irq_ack) m_irq = 0;
    endtask

    task automatic check_all();
        chk("outPC", 32'(outPC), m_pc[m_act]);
        chk("active_ctx", 32'(active_ctx), m_act);
        chk("sw_ack", 32'(sw_ack), 32'(m_ack));
        chk("sw_err", 32'(sw_err), 32'(m_err));
        chk("timer_irq", 32'(timer_irq), 32'(m_irq));
        chk("probe_pc", 32'(probe_pc), int'(probe_ctx) < NUM_CTX ? m_pc[int'(probe_ctx)] : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        hlt = 0; bios_reset = 0; ctx_clear = 0; sw_req = 0; irq_ack = 0;
    endtask

    // Switch with PCs frozen; a same-context request just spends one extra held cycle
    task automatic go_ctx(input int c);
        hlt = 1; sw_req = 1; sw_ctx = CTX_W'(c);
        cyc();
        sw_req = 0;
        cyc();
        hlt = 0;
    endtask

    task automatic bios_during_switch(input bit extras);
        quantum = 2;
        for (int c = 0; c < NUM_CTX; c++) begin
            go_ctx(c);
            address = ADDR_W'(10'h100 + c);
            cyc();
        end
        repeat (3) cyc();
        sw_req = 1; sw_ctx = 1;
        cyc();
        sw_req = 0; bios_reset = 1; hlt = extras; ctx_clear = extras;
        cyc();
        idle();
        chk("t5_active", 32'(active_ctx), 0);
        chk("t5_ack", 32'(sw_ack), 0);
        chk("t5_irq", 32'(timer_irq), 0);
        for (int p = 0; p < NUM_CTX; p++) begin
            probe_ctx = CTX_W'(p);
            #1 chk("t5_probe", 32'(probe_pc), 32'(RV));
        end
        quantum = 0;
        cyc();
        chk("t5_noack", 32'(sw_ack), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1;

        // Test 1: context 0 loads, others stay at reset vector
        address = 10'h005;
        repeat (3) cyc();
        chk("t1_pc", 32'(outPC), 5);
        probe_ctx = 3;
        #1 chk("t1_probe3", 32'(probe_pc), 0);

        // Test 2: switch latency and request-cycle commit to old context
        address = 10'h011; sw_req = 1; sw_ctx = 2;
        cyc();
        sw_req = 0; address = 10'h3ff;
        chk("t2_old_pc", 32'(outPC), 32'h11);
        cyc();
        chk("t2_active", 32'(active_ctx), 2);
        chk("t2_ack", 32'(sw_ack), 1);
        chk("t2_newpc", 32'(outPC), 0);
        address = 10'h0a0; probe_ctx = 0;
        cyc();
        chk("t2_probe0", 32'(probe_pc), 32'h11);
        chk("t2_load", 32'(outPC), 32'ha0);

        // Test 3: quantum timer
        quantum = 4; sw_req = 1; sw_ctx = 1;
        cyc();
        sw_req = 0;
        cyc();
        repeat (3) cyc();
        chk("t3_irq_early", 32'(timer_irq), 0);
        cyc();
        chk("t3_irq", 32'(timer_irq), 1);
        irq_ack = 1;
        cyc();
        irq_ack = 0;
        chk("t3_irq_ack", 32'(timer_irq), 0);
        hlt = 1;
        repeat (2) cyc();
        hlt = 0;
        repeat (3) cyc();
        chk("t3_hlt_early", 32'(timer_irq), 0);
        cyc();
        chk("t3_hlt_irq", 32'(timer_irq), 1);
        irq_ack = 1; sw_req = 1; sw_ctx = 0;
        cyc();
        irq_ack = 0; sw_req = 0;
        cyc();
        chk("t3_ctx0", 32'(active_ctx), 0);
        repeat (10) cyc();
        chk("t3_ctx0_noirq", 32'(timer_irq), 0);

        // Test 4: rejected target, same-context ack, request during SWITCH
        sw_req = 1; sw_ctx = 5;
        cyc();
        sw_req = 0;
        chk("t4_err", 32'(sw_err), 1);
        chk("t4_err_active", 32'(active_ctx), 0);
        sw_req = 1; sw_ctx = 0;
        cyc();
        sw_req = 0;
        chk("t4_same_ack", 32'(sw_ack), 1);
        sw_req = 1; sw_ctx = 1;
        cyc();
        sw_ctx = 3;
        cyc();
        sw_req = 0;
        chk("t4_sw_active", 32'(active_ctx), 1);
        cyc();
        chk("t4_ignored_active", 32'(active_ctx), 1);
        chk("t4_ignored_ack", 32'(sw_ack), 0);

        // Test 5: bios_reset mid-switch dominates everything
        bios_during_switch(0);
        bios_during_switch(1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            address    = ADDR_W'($urandom);
            hlt        = ($urandom_range(0, 3) == 0);
            ctx_clear  = ($urandom_range(0, 19) == 0);
            bios_reset = ($urandom_range(0, 59) == 0);
            sw_req     = ($urandom_range(0, 6) == 0);
            sw_ctx     = CTX_W'($urandom);
            irq_ack    = ($urandom_range(0, 4) == 0);
            probe_ctx  = CTX_W'($urandom);
            if ($urandom_range(0, 99) == 0) quantum = QUANTUM_W'($urandom_range(0, 7));
            cyc();
        end

        // Test 6: async reset between edges on ctx 3 with irq pending
        idle();
        quantum = 2;
        repeat (2) cyc();
        go_ctx(3);
        repeat (4) cyc();
        chk("t6_pre_active", 32'(active_ctx), 3);
        chk("t6_pre_irq", 32'(timer_irq), 1);
        #2 reset = 0;
        #1;
        chk("t6_active", 32'(active_ctx), 0);
        chk("t6_irq", 32'(timer_irq), 0);
        chk("t6_outPC", 32'(outPC), 32'(RV));
        chk("t6_ack", 32'(sw_ack), 0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
